l1_data_cache: RTL and testbench
================================

Name: l1_data_cache

Overview:
- Split-L1 data cache model for the processor/L2 cache-system project: 4-way set-associative, write-back, write-allocate, MESI line states, true-LRU replacement.
- Consumes one trace command per accepted cycle (code + 32-bit address).
- Emits L2 bus messages carrying a 26-bit line address.
- Maintains hit/miss/read/write statistics counters read by the stats/print block.

Parameters:
- INDEX_BITS, 14, set index width (SETS = 2**INDEX_BITS)
- WAYS, 4, associativity (fixed at 4; LRU logic sized for it)
- OFFSET_BITS, 6, byte offset in 64-byte line
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  single clock, rising edge
- clear  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present this cycle
- ready  out  1  command accepted when cmd_valid & ready
- n  in  4  command code
- add_in  in  32  byte address
- l2_valid  out  1  L2 message strobe, one cycle per message
- l2_op  out  2  0 READ, 1 WRITE(writeback), 2 RFO, 3 INVALIDATE
- add_out  out  26  line address of L2 message = add_in[31:6] or victim {tag,index}
- hit  out  CNT_W  read+write hits
- miss  out  CNT_W  read+write misses
- reads  out  CNT_W  read commands
- writes  out  CNT_W  write commands

Behaviour:
- Address split: tag = [31:INDEX_BITS+6], index = [INDEX_BITS+5:6], offset ignored.
- Reset (clear high, async) and command 8 (synchronous) both do the following:
  - all line states to I and all LRU ages to 0..3 by way number (way 0 most recent);
  - counters to 0;
  - l2_valid 0, add_out 0, l2_op 0, ready 1.
- Command codes:
  - 0 data read: reads+1.
    - Hit (state != I, tag match): hit+1, state unchanged.
    - Miss: miss+1, allocate, READ message, state E.
  - 1 data write: writes+1.
    - Hit in M or E: hit+1, state M, no message.
    - Hit in S: hit+1, INVALIDATE message, state M.
    - Miss: miss+1, allocate, RFO message, state M.
  - 3 snoop invalidate: matching line to I. If the line was M, first send a WRITE message. No counters change, no LRU update.
  - 4 snoop read: line in M sends a WRITE message and goes to S; line in E goes to S; S and I are unchanged. No counters change, no LRU update.
  - 9 print, 2 instruction fetch, all other codes: no-op, accepted in one cycle.
- Allocation: victim is the lowest-numbered invalid way, else the LRU way. A victim in M sends WRITE (victim line address) before the fill message.
- LRU: 2-bit age per way. On read/write access to way w, every way with age < age(w) increments and way w is set to 0. LRU way = age 3.
- Timing:
  - Lookup and state update happen in the accept cycle; the first message is registered, so l2_valid is high the following cycle.
  - Two-message case (dirty eviction + fill, or snoop invalidate of M): ready drops for one cycle; WRITE appears in cycle+1, fill or none in cycle+2.
  - Counters update at the accept edge.
  - l2_valid deasserts when there is no message.
- Counters wrap modulo 2**CNT_W.
- Commands presented while ready=0 are ignored; the source holds them.
- clear asserted mid two-message sequence aborts the sequence; the pending message is dropped.

Decomposition:
- Shared package holds:
  - MESI state enum (I,S,E,M);
  - command code constants 0,1,2,3,4,8,9;
  - L2 op constants;
  - address field widths.
- One natural sub-module: dcache_lru (per-set age update and victim select, combinational), instantiated once on the indexed set.
- Instruction-cache sibling reuses the package and dcache_lru.

Test Plan:
- Reset, then read 0x00000040: miss, READ with add_out=0x0000001. Repeat the read: hit, no message. Counters: reads=2, hit=1, miss=1.
- Write 0x00000080: RFO with add_out 0x0000002, state M. Write again: hit, no message. writes=2, miss=1.
- Write 0x00000000, 0x00100000, 0x00200000, 0x00300000 (all set 0, all M), then read 0x00400000: WRITE add_out=0x0000000, then READ add_out=0x0010000; ready low one cycle.
- Write 0x00000100 (M), cmd 4 same address: WRITE 0x0000004, state S. Write 0x00000100: INVALIDATE 0x0000004, hit+1.
- Read 0x00000140 (E), cmd 3 same address: no message. Read again: miss, READ 0x0000005.
- Cmd 8 after traffic: all counters 0, previous line misses. Repeat via async clear asserted between clock edges: same result immediately.

Source files
------------

// File: rtl/l1_data_cache_pkg.sv
// Shared definitions for the L1 data cache and its instruction-cache sibling.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l1_data_cache_pkg;

    // Address layout: 32-bit byte address, 64-byte lines, 26-bit line address on L2.
    localparam int ADDR_W      = 32;
    localparam int OFFSET_W    = 6;
    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;
    localparam int CMD_W       = 4;

    // Replacement bookkeeping is built for exactly four ways.
    localparam int LRU_WAYS  = 4;
    localparam int LRU_WAY_W = 2;
    localparam int AGE_W     = 2;

    // Ages after reset/flush: way w has age w, so way 0 is most recent.
    localparam logic [LRU_WAYS-1:0][AGE_W-1:0] LRU_AGE_INIT = {2'd3, 2'd2, 2'd1, 2'd0};

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    localparam logic [CMD_W-1:0] CMD_READ      = 4'd0;
    localparam logic [CMD_W-1:0] CMD_WRITE     = 4'd1;
    localparam logic [CMD_W-1:0] CMD_IFETCH    = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SNOOP_INV = 4'd3;
    localparam logic [CMD_W-1:0] CMD_SNOOP_RD  = 4'd4;
    localparam logic [CMD_W-1:0] CMD_RESET     = 4'd8;
    localparam logic [CMD_W-1:0] CMD_PRINT     = 4'd9;

    localparam logic [1:0] L2_READ  = 2'd0;
    localparam logic [1:0] L2_WRITE = 2'd1;
    localparam logic [1:0] L2_RFO   = 2'd2;
    localparam logic [1:0] L2_INV   = 2'd3;

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age update and victim pick for one 4-way set.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on the indexed set.
// Ports: age_in (current ages), acc_way (way being touched),
//        age_out (ages after the touch), lru_way (way holding age 3).
module dcache_lru
    import l1_data_cache_pkg::*;
(
    input  logic [LRU_WAYS-1:0][AGE_W-1:0] age_in,
    input  logic [LRU_WAY_W-1:0]           acc_way,
    output logic [LRU_WAYS-1:0][AGE_W-1:0] age_out,
    output logic [LRU_WAY_W-1:0]           lru_way
);

    logic [AGE_W-1:0] acc_age;

    always_comb begin
        acc_age = age_in[acc_way];
        age_out = age_in;
        lru_way = '0;
        for (int w = 0; w < LRU_WAYS; w++) begin
            if (age_in[w] == 2'd3) begin
                lru_way = LRU_WAY_W'(w);
            end
            // Ages form a permutation: only ways younger than the touched one age.
            if (LRU_WAY_W'(w) == acc_way) begin
                age_out[w] = '0;
            end else if (age_in[w] < acc_age) begin
                age_out[w] = age_in[w] + 2'd1;
            end
        end
    end

endmodule

// File: rtl/l1_data_cache.sv
// 4-way write-back/write-allocate MESI L1 data cache with L2 message output and stats.
// Latency: lookup/update at accept edge; first L2 message registered one cycle later.
// Backpressure: ready drops for one cycle when a command produces two L2 messages.
// Ports: clk/clear (async active-high), cmd_valid/ready/n/add_in command in,
//        l2_valid/l2_op/add_out message out, hit/miss/reads/writes counters.
module l1_data_cache
    import l1_data_cache_pkg::*;
#(
    parameter int INDEX_BITS  = 14,
    parameter int WAYS        = 4,
    parameter int OFFSET_BITS = 6,
    parameter int CNT_W       = 32
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             cmd_valid,
    output logic                             ready,
    input  logic [CMD_W-1:0]                 n,
    input  logic [ADDR_W-1:0]                add_in,
    output logic                             l2_valid,
    output logic [1:0]                       l2_op,
    output logic [ADDR_W-OFFSET_BITS-1:0]    add_out,
    output logic [CNT_W-1:0]                 hit,
    output logic [CNT_W-1:0]                 miss,
    output logic [CNT_W-1:0]                 reads,
    output logic [CNT_W-1:0]                 writes
);

    localparam int SETS   = 1 << INDEX_BITS;
    localparam int TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_W = ADDR_W - OFFSET_BITS;
    localparam int WAY_W  = LRU_WAY_W;

    typedef enum logic {ST_IDLE, ST_SECOND} seq_t;

    // Line storage. States and ages are qualified by set_live so that reset and
    // flush clear every set at once without touching the arrays themselves.
    logic [WAYS-1:0][1:0]       st_q   [SETS];
    logic [WAYS-1:0][AGE_W-1:0] age_q  [SETS];
    logic [WAYS-1:0][TAG_W-1:0] tag_q  [SETS];
    logic [SETS-1:0]            set_live;

    logic [TAG_W-1:0]           tag;
    logic [INDEX_BITS-1:0]      idx;
    logic [LINE_W-1:0]          line_addr;
    logic                       unused_offset;

    logic [WAYS-1:0][1:0]       set_st;
    logic [WAYS-1:0][AGE_W-1:0] set_age;
    logic [WAYS-1:0][TAG_W-1:0] set_tag;

    logic                       hit_any, inv_any;
    logic [WAY_W-1:0]           hit_way, inv_way, lru_way, victim, acc_way;
    logic [WAYS-1:0][AGE_W-1:0] age_nxt;
    logic [LINE_W-1:0]          victim_addr;

    seq_t                       seq_q, seq_d;
    logic                       accept;

    logic                       is_wr, st_we, age_we, tag_we, mem_we, two_msg, do_flush;
    logic                       inc_rd, inc_wr, inc_hit, inc_miss;
    mesi_t                      st_nxt;
    logic [WAYS-1:0][1:0]       st_set_nxt;
    logic [1:0]                 fill_op;
    logic                       m1_vld, m2_vld;
    logic [1:0]                 m1_op, m2_op;
    logic [LINE_W-1:0]          m1_addr, m2_addr;

    logic                       pend_vld;
    logic [1:0]                 pend_op;
    logic [LINE_W-1:0]          pend_addr;

    assign tag           = add_in[ADDR_W-1 -: TAG_W];
    assign idx           = add_in[OFFSET_BITS +: INDEX_BITS];
    assign line_addr     = add_in[ADDR_W-1:OFFSET_BITS];
    assign unused_offset = ^add_in[OFFSET_BITS-1:0];

    assign set_st  = set_live[idx] ? st_q[idx]  : '0;
    assign set_age = set_live[idx] ? age_q[idx] : LRU_AGE_INIT;
    assign set_tag = tag_q[idx];

    // Tag match and lowest invalid way (descending loop leaves the lowest).
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (set_st[w] != MESI_I && set_tag[w] == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (set_st[w] == MESI_I) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign victim      = inv_any ? inv_way : lru_way;
    assign acc_way     = hit_any ? hit_way : victim;
    assign victim_addr = {set_tag[victim], idx};

    dcache_lru u_lru (
        .age_in  (set_age),
        .acc_way (acc_way),
        .age_out (age_nxt),
        .lru_way (lru_way)
    );

    // Sequencer: IDLE accepts commands; SECOND drains the queued second message.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            seq_q <= ST_IDLE;
        end else begin
            seq_q <= seq_d;
        end
    end

    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            ST_IDLE:   if (accept && two_msg) seq_d = ST_SECOND;
            ST_SECOND: seq_d = ST_IDLE;
            default:   seq_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (seq_q == ST_IDLE);
    end

    assign accept = cmd_valid & ready;

    // Command decode: state/LRU/tag writes, messages and counter strobes.
    always_comb begin
        is_wr    = (n == CMD_WRITE);
        fill_op  = is_wr ? L2_RFO : L2_READ;
        st_we    = 1'b0;
        st_nxt   = MESI_I;
        age_we   = 1'b0;
        tag_we   = 1'b0;
        two_msg  = 1'b0;
        do_flush = 1'b0;
        inc_rd   = 1'b0;
        inc_wr   = 1'b0;
        inc_hit  = 1'b0;
        inc_miss = 1'b0;
        m1_vld   = 1'b0;
        m1_op    = L2_READ;
        m1_addr  = line_addr;
        m2_vld   = 1'b0;
        m2_op    = L2_READ;
        m2_addr  = line_addr;
        if (accept) begin
            case (n)
                CMD_READ, CMD_WRITE: begin
                    inc_rd = ~is_wr;
                    inc_wr = is_wr;
                    age_we = 1'b1;
                    if (hit_any) begin
                        inc_hit = 1'b1;
                        if (is_wr) begin
                            st_we  = 1'b1;
                            st_nxt = MESI_M;
                            // Shared copies elsewhere must be killed before owning the line.
                            if (set_st[hit_way] == MESI_S) begin
                                m1_vld = 1'b1;
                                m1_op  = L2_INV;
                            end
                        end
                    end else begin
                        inc_miss = 1'b1;
                        st_we    = 1'b1;
                        tag_we   = 1'b1;
                        st_nxt   = is_wr ? MESI_M : MESI_E;
                        if (set_st[victim] == MESI_M) begin
                            m1_vld  = 1'b1;
                            m1_op   = L2_WRITE;
                            m1_addr = victim_addr;
                            two_msg = 1'b1;
                            m2_vld  = 1'b1;
                            m2_op   = fill_op;
                        end else begin
                            m1_vld = 1'b1;
                            m1_op  = fill_op;
                        end
                    end
                end
                CMD_SNOOP_INV: begin
                    if (hit_any) begin
                        st_we  = 1'b1;
                        st_nxt = MESI_I;
                        // Dirty data is written back; the slot after it carries nothing.
                        if (set_st[hit_way] == MESI_M) begin
                            m1_vld  = 1'b1;
                            m1_op   = L2_WRITE;
                            two_msg = 1'b1;
                        end
                    end
                end
                CMD_SNOOP_RD: begin
                    if (hit_any && (set_st[hit_way] == MESI_M || set_st[hit_way] == MESI_E)) begin
                        st_we  = 1'b1;
                        st_nxt = MESI_S;
                        if (set_st[hit_way] == MESI_M) begin
                            m1_vld = 1'b1;
                            m1_op  = L2_WRITE;
                        end
                    end
                end
                CMD_RESET: do_flush = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        st_set_nxt = set_st;
        if (st_we) begin
            st_set_nxt[acc_way] = st_nxt;
        end
    end

    assign mem_we = st_we | age_we;

    // Array writes carry the whole set so a freshly revived set starts from clean values.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            st_q[idx]  <= st_set_nxt;
            age_q[idx] <= age_we ? age_nxt : set_age;
        end
        if (tag_we) begin
            tag_q[idx][acc_way] <= tag;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            set_live <= '0;
        end else if (do_flush) begin
            set_live <= '0;
        end else if (mem_we) begin
            set_live[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            hit    <= '0;
            miss   <= '0;
            reads  <= '0;
            writes <= '0;
        end else if (do_flush) begin
            hit    <= '0;
            miss   <= '0;
            reads  <= '0;
            writes <= '0;
        end else begin
            if (inc_hit)  hit    <= hit    + CNT_W'(1);
            if (inc_miss) miss   <= miss   + CNT_W'(1);
            if (inc_rd)   reads  <= reads  + CNT_W'(1);
            if (inc_wr)   writes <= writes + CNT_W'(1);
        end
    end

    // Message output: first message at the accept edge, second one edge later.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            l2_valid  <= 1'b0;
            l2_op     <= '0;
            add_out   <= '0;
            pend_vld  <= 1'b0;
            pend_op   <= '0;
            pend_addr <= '0;
        end else if (do_flush) begin
            l2_valid  <= 1'b0;
            l2_op     <= '0;
            add_out   <= '0;
            pend_vld  <= 1'b0;
            pend_op   <= '0;
            pend_addr <= '0;
        end else if (accept) begin
            l2_valid  <= m1_vld;
            l2_op     <= m1_op;
            add_out   <= m1_addr;
            pend_vld  <= m2_vld;
            pend_op   <= m2_op;
            pend_addr <= m2_addr;
        end else if (seq_q == ST_SECOND) begin
            l2_valid  <= pend_vld;
            l2_op     <= pend_op;
            add_out   <= pend_addr;
            pend_vld  <= 1'b0;
        end else begin
            l2_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l1_data_cache.sv
// Bench for l1_data_cache: directed vector table, hand sequences, random vs model.
// Latency: n/a.
// Backpressure: commands wait (bounded) for ready before being driven.
module tb_l1_data_cache;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_WB   = 2'd1;
    localparam logic [1:0] OP_RFO  = 2'd2;
    localparam logic [1:0] OP_INV  = 2'd3;
    localparam int K_NONE = 0;
    localparam int K_HIT  = 1;
    localparam int K_MISS = 2;
    localparam int MI = 0, MS = 1, ME = 2, MM = 3;
    localparam logic [28:0] NONE = 29'd0;
    localparam int NV = 27;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] addr;
        int          kind;
        logic [28:0] m1;
        logic        drop;
        logic [28:0] m2;
    } vec_t;

    logic        clk, clear, cmd_valid, ready, l2_valid;
    logic [3:0]  n;
    logic [31:0] add_in;
    logic [1:0]  l2_op;
    logic [25:0] add_out;
    logic [31:0] hit_o, miss_o, reads_o, writes_o;

    int checks = 0;
    int failures = 0;
    int e_hit = 0, e_miss = 0, e_rd = 0, e_wr = 0;
    logic [28:0] got_m1, got_m2;
    logic        got_drop;
    vec_t        tbl [NV];

    // Reference model for sets 0..3: per-way state/tag plus a recency list.
    int m_st  [4][4];
    int m_tag [4][4];
    int m_ord [4][4];

    l1_data_cache dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .ready     (ready),
        .n         (n),
        .add_in    (add_in),
        .l2_valid  (l2_valid),
        .l2_op     (l2_op),
        .add_out   (add_out),
        .hit       (hit_o),
        .miss      (miss_o),
        .reads     (reads_o),
        .writes    (writes_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [28:0] msg(input logic [1:0] op, input logic [25:0] a);
        return {1'b1, op, a};
    endfunction

    function automatic vec_t vec(input logic [3:0] c, input logic [31:0] a, input int k,
                                 input logic [28:0] m1, input logic d, input logic [28:0] m2);
        vec_t v;
        v.code = c; v.addr = a; v.kind = k; v.m1 = m1; v.drop = d; v.m2 = m2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_counters(input string name);
        check({name, "_hit"},    64'(hit_o),    64'(e_hit));
        check({name, "_miss"},   64'(miss_o),   64'(e_miss));
        check({name, "_reads"},  64'(reads_o),  64'(e_rd));
        check({name, "_writes"}, 64'(writes_o), 64'(e_wr));
    endtask

    function automatic logic [28:0] cur_msg();
        return l2_valid ? {1'b1, l2_op, add_out} : NONE;
    endfunction

    // Called at a negedge; returns at a negedge with observed messages.
    task automatic issue(input logic [3:0] c, input logic [31:0] a);
        int guard;
        guard = 0;
        while (!ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 64'(ready), 64'd1);
        cmd_valid = 1'b1;
        n = c;
        add_in = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        got_m1 = cur_msg();
        got_drop = ~ready;
        got_m2 = NONE;
        if (got_drop) begin
            @(negedge clk);
            got_m2 = cur_msg();
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_st[s][w] = MI;
                m_tag[s][w] = 0;
                m_ord[s][w] = w;
            end
        end
        e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
    endtask

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int k = 0; k < 4; k++) if (m_ord[s][k] == w) p = k;
        for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
        m_ord[s][0] = w;
    endtask

    task automatic model_cmd(input logic [3:0] c, input logic [31:0] a,
                             output logic [28:0] x1, output logic xd, output logic [28:0] x2);
        int s, t, hw, v;
        logic [1:0] fill;
        s = int'(a[19:6]);
        t = int'(a[31:20]);
        x1 = NONE; x2 = NONE; xd = 1'b0; hw = -1;
        for (int w = 0; w < 4; w++) if (m_st[s][w] != MI && m_tag[s][w] == t) hw = w;
        case (c)
            4'd0, 4'd1: begin
                if (c == 4'd0) e_rd++; else e_wr++;
                if (hw >= 0) begin
                    e_hit++;
                    if (c == 4'd1) begin
                        if (m_st[s][hw] == MS) x1 = msg(OP_INV, a[31:6]);
                        m_st[s][hw] = MM;
                    end
                    touch(s, hw);
                end else begin
                    e_miss++;
                    v = -1;
                    for (int w = 3; w >= 0; w--) if (m_st[s][w] == MI) v = w;
                    if (v < 0) v = m_ord[s][3];
                    fill = (c == 4'd0) ? OP_READ : OP_RFO;
                    if (m_st[s][v] == MM) begin
                        x1 = msg(OP_WB, 26'(m_tag[s][v] * 16384 + s));
                        x2 = msg(fill, a[31:6]);
                        xd = 1'b1;
                    end else begin
                        x1 = msg(fill, a[31:6]);
                    end
                    m_tag[s][v] = t;
                    m_st[s][v] = (c == 4'd0) ? ME : MM;
                    touch(s, v);
                end
            end
            4'd3: if (hw >= 0) begin
                if (m_st[s][hw] == MM) begin
                    x1 = msg(OP_WB, a[31:6]);
                    xd = 1'b1;
                end
                m_st[s][hw] = MI;
            end
            4'd4: if (hw >= 0) begin
                if (m_st[s][hw] == MM) x1 = msg(OP_WB, a[31:6]);
                if (m_st[s][hw] == MM || m_st[s][hw] == ME) m_st[s][hw] = MS;
            end
            4'd8: model_reset();
            default: ;
        endcase
    endtask

    initial begin
        logic [28:0] x1, x2;
        logic        xd;
        logic [3:0]  c;
        logic [31:0] a;
        int          r;

        tbl[0]  = vec(4'd0, 32'h0000_0040, K_MISS, msg(OP_READ, 26'h1),     1'b0, NONE);
        tbl[1]  = vec(4'd0, 32'h0000_0040, K_HIT,  NONE,                    1'b0, NONE);
        tbl[2]  = vec(4'd1, 32'h0000_0080, K_MISS, msg(OP_RFO, 26'h2),      1'b0, NONE);
        tbl[3]  = vec(4'd1, 32'h0000_0080, K_HIT,  NONE,                    1'b0, NONE);
        tbl[4]  = vec(4'd1, 32'h0000_0000, K_MISS, msg(OP_RFO, 26'h0),      1'b0, NONE);
        tbl[5]  = vec(4'd1, 32'h0010_0000, K_MISS, msg(OP_RFO, 26'h4000),   1'b0, NONE);
        tbl[6]  = vec(4'd1, 32'h0020_0000, K_MISS, msg(OP_RFO, 26'h8000),   1'b0, NONE);
        tbl[7]  = vec(4'd1, 32'h0030_0000, K_MISS, msg(OP_RFO, 26'hC000),   1'b0, NONE);
        tbl[8]  = vec(4'd0, 32'h0040_0000, K_MISS, msg(OP_WB, 26'h0),       1'b1, msg(OP_READ, 26'h10000));
        tbl[9]  = vec(4'd0, 32'h0010_0000, K_HIT,  NONE,                    1'b0, NONE);
        tbl[10] = vec(4'd0, 32'h0050_0000, K_MISS, msg(OP_WB, 26'h8000),    1'b1, msg(OP_READ, 26'h14000));
        tbl[11] = vec(4'd1, 32'h0000_0100, K_MISS, msg(OP_RFO, 26'h4),      1'b0, NONE);
        tbl[12] = vec(4'd4, 32'h0000_0100, K_NONE, msg(OP_WB, 26'h4),       1'b0, NONE);
        tbl[13] = vec(4'd1, 32'h0000_0100, K_HIT,  msg(OP_INV, 26'h4),      1'b0, NONE);
        tbl[14] = vec(4'd0, 32'h0000_0140, K_MISS, msg(OP_READ, 26'h5),     1'b0, NONE);
        tbl[15] = vec(4'd3, 32'h0000_0140, K_NONE, NONE,                    1'b0, NONE);
        tbl[16] = vec(4'd0, 32'h0000_0140, K_MISS, msg(OP_READ, 26'h5),     1'b0, NONE);
        tbl[17] = vec(4'd1, 32'h0000_0180, K_MISS, msg(OP_RFO, 26'h6),      1'b0, NONE);
        tbl[18] = vec(4'd3, 32'h0000_0180, K_NONE, msg(OP_WB, 26'h6),       1'b1, NONE);
        tbl[19] = vec(4'd0, 32'h0000_0180, K_MISS, msg(OP_READ, 26'h6),     1'b0, NONE);
        tbl[20] = vec(4'd4, 32'h0000_0040, K_NONE, NONE,                    1'b0, NONE);
        tbl[21] = vec(4'd1, 32'h0000_0040, K_HIT,  msg(OP_INV, 26'h1),      1'b0, NONE);
        tbl[22] = vec(4'd2, 32'h0000_0040, K_NONE, NONE,                    1'b0, NONE);
        tbl[23] = vec(4'd9, 32'h0000_0000, K_NONE, NONE,                    1'b0, NONE);
        tbl[24] = vec(4'd7, 32'h0000_0040, K_NONE, NONE,                    1'b0, NONE);
        tbl[25] = vec(4'd4, 32'h007F_F000, K_NONE, NONE,                    1'b0, NONE);
        tbl[26] = vec(4'd0, 32'h0000_007F, K_HIT,  NONE,                    1'b0, NONE);

        // Reset state.
        clear = 1'b1; cmd_valid = 1'b0; n = 4'd0; add_in = 32'd0;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_l2", 64'({l2_valid, l2_op, add_out}), 64'd0);
        check_counters("rst");
        clear = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].code, tbl[i].addr);
            check($sformatf("v%0d_msg1", i), 64'(got_m1), 64'(tbl[i].m1));
            check($sformatf("v%0d_drop", i), 64'(got_drop), 64'(tbl[i].drop));
            if (tbl[i].drop) check($sformatf("v%0d_msg2", i), 64'(got_m2), 64'(tbl[i].m2));
            if (tbl[i].code == 4'd0) e_rd++;
            if (tbl[i].code == 4'd1) e_wr++;
            if (tbl[i].kind == K_HIT) e_hit++;
            if (tbl[i].kind == K_MISS) e_miss++;
            if (i == 1 || i == 10) check_counters($sformatf("v%0d_cnt", i));
        end
        check_counters("table_end");

        // Synchronous flush via command 8.
        issue(4'd8, 32'd0);
        e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
        check("flush_l2", 64'({l2_valid, l2_op, add_out}), 64'd0);
        check("flush_ready", 64'(ready), 64'd1);
        check_counters("flush");
        issue(4'd0, 32'h0000_0040);
        check("flush_rd_msg", 64'(got_m1), 64'(msg(OP_READ, 26'h1)));
        e_rd = 1; e_miss = 1;
        check_counters("flush_rd");

        // Asynchronous clear between edges.
        issue(4'd1, 32'h0000_0080);
        check("aclr_pre_msg", 64'(got_m1), 64'(msg(OP_RFO, 26'h2)));
        #2 clear = 1'b1;
        #1;
        e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
        check_counters("aclr");
        check("aclr_l2", 64'({l2_valid, l2_op, add_out}), 64'd0);
        #1 clear = 1'b0;
        @(negedge clk);
        issue(4'd1, 32'h0000_0080);
        check("aclr_wr_msg", 64'(got_m1), 64'(msg(OP_RFO, 26'h2)));
        e_wr = 1; e_miss = 1;

        // A command held while ready is low is taken exactly once.
        issue(4'd1, 32'h0000_0000);
        issue(4'd1, 32'h0010_0000);
        issue(4'd1, 32'h0020_0000);
        issue(4'd1, 32'h0030_0000);
        check("fill3_msg", 64'(got_m1), 64'(msg(OP_RFO, 26'hC000)));
        e_wr += 4; e_miss += 4;
        cmd_valid = 1'b1; n = 4'd0; add_in = 32'h0040_0000;
        @(negedge clk);
        check("hold_m1", 64'(cur_msg()), 64'(msg(OP_WB, 26'h0)));
        check("hold_busy", 64'(ready), 64'd0);
        @(negedge clk);
        check("hold_m2", 64'(cur_msg()), 64'(msg(OP_READ, 26'h10000)));
        check("hold_ready", 64'(ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_hit_msg", 64'(cur_msg()), 64'(NONE));
        e_rd += 2; e_miss += 1; e_hit += 1;
        check_counters("hold");

        // Clear in the middle of a two-message sequence drops the pending fill.
        cmd_valid = 1'b1; n = 4'd0; add_in = 32'h0050_0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_m1", 64'(cur_msg()), 64'(msg(OP_WB, 26'h4000)));
        #2 clear = 1'b1;
        #1;
        check("abort_l2", 64'(l2_valid), 64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        #1 clear = 1'b0;
        @(negedge clk);
        check("abort_nofill", 64'(l2_valid), 64'd0);
        e_hit = 0; e_miss = 0; e_rd = 0; e_wr = 0;
        check_counters("abort");

        // Random traffic on a few sets with a small tag pool.
        issue(4'd8, 32'd0);
        model_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35) c = 4'd0;
            else if (r < 70) c = 4'd1;
            else if (r < 80) c = 4'd3;
            else if (r < 90) c = 4'd4;
            else if (r < 99) begin
                c = 4'($urandom_range(0, 15));
                if (c inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd8}) c = 4'd9;
            end else c = 4'd8;
            a = (32'($urandom_range(0, 5)) << 20) | (32'($urandom_range(0, 3)) << 6)
                | 32'($urandom_range(0, 63));
            model_cmd(c, a, x1, xd, x2);
            issue(c, a);
            check($sformatf("rnd%0d_msg1", i), 64'(got_m1), 64'(x1));
            check($sformatf("rnd%0d_drop", i), 64'(got_drop), 64'(xd));
            if (xd) check($sformatf("rnd%0d_msg2", i), 64'(got_m2), 64'(x2));
            if (i % 50 == 49) check_counters($sformatf("rnd%0d_cnt", i));
        end
        check_counters("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
